// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the multi-channel memory controller CSR block.
package mem_ctrl_pkg;
  localparam logic [3:0] ID_OFF   = 4'h0;
  localparam logic [3:0] ERR_OFF  = 4'h4;
  localparam logic [3:0] IRQ_OFF  = 4'h8;
  localparam logic [3:0] CTRL_OFF = 4'h0;
  localparam logic [3:0] CFG_OFF  = 4'h4;
  localparam logic [3:0] STAT_OFF = 4'h8;
  localparam int unsigned CH_BASE   = 32'h10;
  localparam int unsigned CH_STRIDE = 32'h10;

  localparam int ERR_COLL  = 0;
  localparam int ERR_BUSY  = 1;
  localparam int ERR_UNMAP = 2;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} ch_state_e;

  // STATUS register image: bit0 busy, bit1 done, [15:8] beats remaining
  typedef struct packed {
    logic [7:0] beats;
    logic [5:0] rsvd;
    logic       done;
    logic       busy;
  } ch_stat_t;

  function automatic logic reg_off_ok(input logic [3:0] off);
    return (off == 4'h0) || (off == 4'h4) || (off == 4'h8);
  endfunction
endpackage

// File: rtl/mem_ctrl_mc_seq.sv
// Per-channel command sequencer: latency phase, burst-beat phase, sticky done.
module mem_ch_seq
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        done_clr,
  input  logic [3:0]  mode_in,
  input  logic [11:0] cfg,
  output logic        pulse,
  output logic        beat,
  output logic        start_err,
  output logic [3:0]  mode,
  output ch_stat_t    stat
);
  ch_state_e  state, state_d;
  logic [7:0] cnt, cnt_d, blen, blen_d;
  logic [3:0] mode_d;
  logic       done, done_set;

  // cnt holds remaining latency cycles in WAIT and remaining beats in BURST
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    blen_d   = blen;
    mode_d   = mode;
    done_set = 1'b0;
    case (state)
      IDLE: if (start) begin
        mode_d = mode_in;
        blen_d = cfg[7:0];
        if (cfg[11:8] != 4'h0) begin
          state_d = WAIT;
          cnt_d   = {4'h0, cfg[11:8]} - 8'd1;
        end else if (cfg[7:0] != 8'h0) begin
          state_d = BURST;
          cnt_d   = cfg[7:0];
        end else begin
          done_set = 1'b1;
        end
      end
      WAIT: if (cnt == 8'd0) begin
        if (blen != 8'h0) begin
          state_d = BURST;
          cnt_d   = blen;
        end else begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end else begin
        cnt_d = cnt - 8'd1;
      end
      BURST: if (cnt == 8'd1) begin
        state_d  = IDLE;
        cnt_d    = 8'd0;
        done_set = 1'b1;
      end else begin
        cnt_d = cnt - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      blen  <= '0;
      mode  <= '0;
      done  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      blen  <= blen_d;
      mode  <= mode_d;
      done  <= done_set | (done & ~done_clr);
      pulse <= start && (state == IDLE);
    end
  end

  assign beat       = (state == BURST);
  assign start_err  = start && (state != IDLE);
  assign stat.beats = beat ? cnt : 8'h0;
  assign stat.rsvd  = '0;
  assign stat.done  = done;
  assign stat.busy  = (state != IDLE);
endmodule

// File: rtl/mem_ctrl_mc.sv
// Multi-channel memory controller CSR slave: decode, ERROR/IRQ_EN, read mux, per-channel sequencers.
module mem_ctrl_mc
  import mem_ctrl_pkg::*;
#(
  parameter int          NUM_CH   = 2,
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'h1234_ABCE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csr_wr_en,
  input  logic                  csr_rd_en,
  input  logic [ADDR_W-1:0]     csr_addr,
  input  logic [DATA_W-1:0]     csr_wr_data,
  output logic [DATA_W-1:0]     csr_rd_data,
  output logic                  csr_rd_valid,
  output logic [NUM_CH-1:0]     mem_start,
  output logic [4*NUM_CH-1:0]   mem_mode,
  output logic [8*NUM_CH-1:0]   mem_burst_length,
  output logic [4*NUM_CH-1:0]   mem_latency,
  output logic [NUM_CH-1:0]     mem_beat,
  output logic [NUM_CH-1:0]     busy,
  output logic                  error_flag,
  output logic                  irq
);
  localparam int PW = ADDR_W - 4;

  logic [PW-1:0]                  page;
  logic [3:0]                     off;
  logic                           glob_hit, mapped;
  logic [NUM_CH-1:0]              ch_hit, start, done_clr, start_err, done;
  logic [NUM_CH-1:0][3:0]         mode;
  logic [NUM_CH-1:0][DATA_W-1:0]  cfg;
  ch_stat_t [NUM_CH-1:0]          stat;
  logic [2:0]                     err, err_set, err_clr;
  logic [DATA_W-1:0]              irq_en, rdata;

  always_comb begin
    page     = csr_addr[ADDR_W-1:4];
    off      = csr_addr[3:0];
    glob_hit = (page == '0) && reg_off_ok(off);
    for (int c = 0; c < NUM_CH; c++)
      ch_hit[c] = reg_off_ok(off) && (page == PW'((CH_BASE + CH_STRIDE * c) >> 4));
    mapped = glob_hit | (|ch_hit);
    for (int c = 0; c < NUM_CH; c++) begin
      start[c]    = csr_wr_en && ch_hit[c] && (off == CTRL_OFF) && csr_wr_data[0];
      done_clr[c] = csr_wr_en && ch_hit[c] && (off == STAT_OFF) && csr_wr_data[1];
      done[c]     = stat[c].done;
      mem_burst_length[8*c +: 8] = cfg[c][7:0];
      mem_latency[4*c +: 4]      = cfg[c][11:8];
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mem_ch_seq u_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[c]),
      .done_clr  (done_clr[c]),
      .mode_in   (csr_wr_data[4:1]),
      .cfg       (cfg[c][11:0]),
      .pulse     (mem_start[c]),
      .beat      (mem_beat[c]),
      .start_err (start_err[c]),
      .mode      (mode[c]),
      .stat      (stat[c])
    );
    assign busy[c] = stat[c].busy;
  end

  // hardware sets are OR-ed in after the W1C clear so a same-cycle set wins
  always_comb begin
    err_set            = '0;
    err_set[ERR_COLL]  = csr_rd_en && csr_wr_en;
    err_set[ERR_BUSY]  = |start_err;
    err_set[ERR_UNMAP] = (csr_rd_en || csr_wr_en) && !mapped;
    err_clr = (csr_wr_en && glob_hit && (off == ERR_OFF)) ? csr_wr_data[2:0] : 3'b0;
  end

  always_comb begin
    rdata = '0;
    if (glob_hit) begin
      case (off)
        ID_OFF:  rdata = DATA_W'(ID_VALUE);
        ERR_OFF: rdata = DATA_W'(err);
        IRQ_OFF: rdata = irq_en;
        default: ;
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) begin
        case (off)
          CTRL_OFF: rdata = DATA_W'({mode[c], 1'b0});
          CFG_OFF:  rdata = cfg[c];
          STAT_OFF: rdata = DATA_W'(stat[c]);
          default:  ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err          <= '0;
      irq_en       <= '0;
      cfg          <= '0;
      csr_rd_data  <= '0;
      csr_rd_valid <= 1'b0;
    end else begin
      err          <= (err & ~err_clr) | err_set;
      csr_rd_valid <= csr_rd_en;
      if (csr_rd_en) csr_rd_data <= rdata;
      if (csr_wr_en && glob_hit && (off == IRQ_OFF)) irq_en <= csr_wr_data;
      for (int c = 0; c < NUM_CH; c++)
        if (csr_wr_en && ch_hit[c] && (off == CFG_OFF)) cfg[c] <= csr_wr_data;
    end
  end

  assign mem_mode   = mode;
  assign error_flag = |err;
  assign irq        = (|(done & irq_en[NUM_CH-1:0])) | (error_flag & irq_en[31]);
endmodule

// File: tb/tb_mem_ctrl_mc.sv
// Directed bench for mem_ctrl_mc with a read-data scoreboard.
module tb_mem_ctrl_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_wr_en, csr_rd_en;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wr_data, csr_rd_data;
  logic        csr_rd_valid;
  logic [1:0]  mem_start, mem_beat, busy;
  logic [7:0]  mem_mode, mem_latency;
  logic [15:0] mem_burst_length;
  logic        error_flag, irq;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int beat_cnt1 = 0;
  int snap;

  mem_ctrl_mc dut (
    .clk(clk), .rst_n(rst_n), .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en),
    .csr_addr(csr_addr), .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
    .csr_rd_valid(csr_rd_valid), .mem_start(mem_start), .mem_mode(mem_mode),
    .mem_burst_length(mem_burst_length), .mem_latency(mem_latency),
    .mem_beat(mem_beat), .busy(busy), .error_flag(error_flag), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (mem_beat[1]) beat_cnt1++;
    if (csr_rd_valid) begin
      if (exp_q.size() == 0) chk("rd_valid_unexpected", 32'h1, 32'h0);
      else chk("rd_data", csr_rd_data, exp_q.pop_front());
    end
  end

  task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_wr_en = 1'b1; csr_addr = a; csr_wr_data = d;
    @(negedge clk);
    csr_wr_en = 1'b0;
  endtask

  task automatic csr_rd(input logic [7:0] a, input logic [31:0] expv);
    @(negedge clk);
    csr_rd_en = 1'b1; csr_addr = a;
    exp_q.push_back(expv);
    @(negedge clk);
    csr_rd_en = 1'b0;
  endtask

  task automatic csr_rdwr(input logic [7:0] a, input logic [31:0] d, input logic [31:0] expv);
    @(negedge clk);
    csr_rd_en = 1'b1; csr_wr_en = 1'b1; csr_addr = a; csr_wr_data = d;
    exp_q.push_back(expv);
    @(negedge clk);
    csr_rd_en = 1'b0; csr_wr_en = 1'b0;
  endtask

  initial begin
    logic [8:0] bp, sp, yp;
    csr_wr_en = 1'b0; csr_rd_en = 1'b0; csr_addr = '0; csr_wr_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {mem_start, mem_beat, busy, error_flag, irq, csr_rd_valid}, 32'h0);
    chk("rst_mode_lat", {mem_mode, mem_latency, mem_burst_length}, 32'h0);
    chk("rst_rd_data", csr_rd_data, 32'h0);
    rst_n = 1'b1;

    csr_rd(8'h00, 32'h1234_ABCE);
    csr_rd(8'h04, 32'h0);

    // ch0: L=3, B=4, mode 5
    csr_wr(8'h14, 32'h0304);
    chk("cfg0_live", {mem_latency[3:0], mem_burst_length[7:0]}, 32'h304);
    csr_rd(8'h14, 32'h0304);
    csr_wr(8'h10, 32'h0000_000B);
    for (int i = 0; i < 9; i++) begin
      bp[i] = mem_beat[0]; sp[i] = mem_start[0]; yp[i] = busy[0];
      @(negedge clk);
    end
    chk("ch0_beat_pattern", bp, 9'b001111000);
    chk("ch0_start_pattern", sp, 9'b000000001);
    chk("ch0_busy_pattern", yp, 9'b001111111);
    chk("ch0_mode", mem_mode[3:0], 4'h5);
    csr_rd(8'h18, 32'h2);
    csr_rd(8'h10, 32'hA);
    csr_wr(8'h18, 32'h2);
    csr_rd(8'h18, 32'h0);

    // ch1: L=B=0 done immediately, irq via IRQ_EN[1]
    csr_wr(8'h24, 32'h0);
    csr_wr(8'h08, 32'h2);
    chk("irq_idle", irq, 1'b0);
    csr_wr(8'h20, 32'h1);
    chk("ch1_zero_pulse", {mem_start, busy, mem_beat}, 6'b10_00_00);
    chk("ch1_zero_irq", irq, 1'b1);
    @(negedge clk);
    chk("ch1_pulse_once", mem_start, 2'b00);
    csr_rd(8'h28, 32'h2);
    csr_wr(8'h28, 32'h2);
    chk("ch1_irq_cleared", irq, 1'b0);
    csr_rd(8'h28, 32'h0);

    // ch0 START while busy is ignored
    csr_wr(8'h14, 32'h0005);
    csr_wr(8'h10, 32'h3);
    chk("ch0_l0_first_beat", {mem_start[0], mem_beat[0]}, 2'b11);
    csr_rd(8'h18, 32'h0401);
    csr_wr(8'h10, 32'h1F);
    chk("busy_start_err", error_flag, 1'b1);
    chk("busy_start_mode", mem_mode[3:0], 4'h1);
    chk("busy_start_beat", {mem_start[0], mem_beat[0]}, 2'b01);
    @(negedge clk);
    chk("burst_end", {mem_beat[0], busy[0]}, 2'b00);
    csr_rd(8'h04, 32'h2);
    csr_wr(8'h08, 32'h8000_0002);
    chk("irq_err", irq, 1'b1);
    csr_wr(8'h04, 32'h2);
    chk("irq_err_cleared", {error_flag, irq}, 2'b00);

    // read/write collision returns pre-write value
    csr_rdwr(8'h14, 32'h0102, 32'h0005);
    chk("coll_flag", error_flag, 1'b1);
    csr_rd(8'h04, 32'h1);
    csr_rd(8'h14, 32'h0102);

    // unmapped accesses
    csr_rd(8'h3C, 32'h0);
    csr_rd(8'h04, 32'h5);
    csr_wr(8'h04, 32'h7);
    csr_rd(8'h04, 32'h0);
    csr_wr(8'h3C, 32'hFF);
    csr_rd(8'h04, 32'h4);
    csr_rd(8'h3C, 32'h0);
    csr_wr(8'h04, 32'h4);
    // collision set wins over the same-cycle W1C of bit0
    csr_rdwr(8'h04, 32'h5, 32'h0);
    csr_rd(8'h04, 32'h1);
    csr_wr(8'h04, 32'h1);

    // CFG written while busy only affects the next START
    csr_wr(8'h24, 32'h0006);
    snap = beat_cnt1;
    csr_wr(8'h20, 32'h1);
    csr_wr(8'h24, 32'h0001);
    repeat (8) @(negedge clk);
    chk("cfg_busy_beats", beat_cnt1 - snap, 6);
    chk("cfg_busy_live", mem_burst_length[15:8], 8'h01);
    snap = beat_cnt1;
    csr_wr(8'h20, 32'h1);
    repeat (3) @(negedge clk);
    chk("cfg_next_beats", beat_cnt1 - snap, 1);

    // reset mid-burst aborts without done
    csr_wr(8'h14, 32'h0008);
    csr_wr(8'h10, 32'h1);
    chk("pre_rst_beat", mem_beat[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_idle", {mem_beat, busy, mem_start}, 6'b0);
    chk("post_rst_cfg", mem_burst_length, 16'h0);
    csr_rd(8'h18, 32'h0);
    csr_rd(8'h04, 32'h0);
    csr_rd(8'h00, 32'h1234_ABCE);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
